// File: rtl/uart_frame_loader_pkg.sv
// Shared types and helpers for the UART frame loader.
// States, default start-of-frame byte and word geometry.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    function automatic int bytes_per_word(input int n);
        return n / 8;
    endfunction

    // Keep at least one bit so an 8-bit word still has an index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_loader_if.sv
// Byte-in / BRAM-write-out bundle of the UART frame loader.
// slave is the loader side, master is the UART/BRAM side.
interface uart_frame_loader_if #(
    parameter int N     = 16,
    parameter int ABITS = 8
) ();

    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic             recv_error;
    logic [ABITS-1:0] wr_addr;
    logic [N-1:0]     wr_data;
    logic             wr_en;
    logic [7:0]       word_count;
    logic             busy;
    logic             start;
    logic             frame_error;

    modport slave (
        input  rx_valid, rx_byte, recv_error,
        output wr_addr, wr_data, wr_en,
        output word_count, busy, start, frame_error
    );

    modport master (
        output rx_valid, rx_byte, recv_error,
        input  wr_addr, wr_data, wr_en,
        input  word_count, busy, start, frame_error
    );

endinterface

// File: rtl/uart_frame_loader_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled.
// expired is high in the cycle the gap reaches TIMEOUT_CYCLES.
module byte_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || kick || !enable) begin
            cnt_q <= '0;
        end else if (!expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // A byte arriving in the expiry cycle wins over the timeout.
    assign expired = enable && !kick &&
                     (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_frame_loader.sv
// Parses SOF / count / payload / XOR checksum uploads from the UART
// and packs payload bytes little-endian into BRAM words.
module uart_frame_loader
    import uart_frame_pkg::*;
#(
    parameter int          N              = 16,
    parameter int          ABITS          = 8,
    parameter logic [7:0]  SOF            = SOF_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input logic          clk,
    input logic          rst,
    uart_frame_loader_if.slave bus
);

    localparam int BPW = bytes_per_word(N);
    localparam int BW  = idx_width(BPW);
    localparam int XW  = ABITS + 1;

    state_t        state_q, state_d;
    logic [7:0]    w_q;
    logic [7:0]    chk_q;
    logic [XW-1:0] widx_q;
    logic [BW-1:0] bidx_q;
    logic [N-1:0]  word_q, word_nxt;

    logic busy, expired;
    logic last_byte, last_word, w_bad;
    logic do_load, do_byte, do_write;
    logic do_start, do_err;

    assign busy     = (state_q != ST_IDLE);
    assign bus.busy = busy;

    byte_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap (
        .clk    (clk),
        .rst    (rst),
        .enable (busy),
        .kick   (bus.rx_valid),
        .expired(expired)
    );

    assign last_byte = (bidx_q == BW'(BPW - 1));
    assign last_word = (widx_q == XW'(w_q) - XW'(1));
    assign w_bad     = (bus.rx_byte == 8'd0) ||
                       (int'(bus.rx_byte) > (1 << ABITS));

    always_comb begin
        word_nxt = word_q;
        word_nxt[8*int'(bidx_q) +: 8] = bus.rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        do_load  = 1'b0;
        do_byte  = 1'b0;
        do_write = 1'b0;
        do_start = 1'b0;
        do_err   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid && !bus.recv_error &&
                    bus.rx_byte == SOF) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT, ST_DATA, ST_CHECK: begin
                priority case (1'b1)
                    bus.recv_error: begin
                        do_err  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    bus.rx_valid: begin
                        unique case (state_q)
                            ST_COUNT: begin
                                if (w_bad) begin
                                    do_err  = 1'b1;
                                    state_d = ST_IDLE;
                                end else begin
                                    do_load = 1'b1;
                                    state_d = ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                do_byte  = 1'b1;
                                do_write = last_byte;
                                if (last_byte && last_word) begin
                                    state_d = ST_CHECK;
                                end
                            end
                            default: begin
                                do_start = (bus.rx_byte == chk_q);
                                do_err   = (bus.rx_byte != chk_q);
                                state_d  = ST_IDLE;
                            end
                        endcase
                    end
                    expired: begin
                        do_err  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q             <= '0;
            chk_q           <= '0;
            widx_q          <= '0;
            bidx_q          <= '0;
            word_q          <= '0;
            bus.wr_addr     <= '0;
            bus.wr_data     <= '0;
            bus.wr_en       <= 1'b0;
            bus.word_count  <= '0;
            bus.start       <= 1'b0;
            bus.frame_error <= 1'b0;
        end else begin
            bus.wr_en       <= do_write;
            bus.start       <= do_start;
            bus.frame_error <= do_err;
            if (do_load) begin
                w_q    <= bus.rx_byte;
                chk_q  <= '0;
                widx_q <= '0;
                bidx_q <= '0;
            end
            if (do_byte) begin
                chk_q  <= chk_q ^ bus.rx_byte;
                word_q <= word_nxt;
                bidx_q <= last_byte ? '0 : bidx_q + BW'(1);
            end
            if (do_write) begin
                bus.wr_addr <= widx_q[ABITS-1:0];
                bus.wr_data <= word_nxt;
                widx_q      <= widx_q + XW'(1);
            end
            if (do_start) begin
                bus.word_count <= w_q;
            end
        end
    end

endmodule
